// File: rtl/segre_pkg.sv
// Shared types and default geometry for the segre cache/memory subsystem.
// The memory arbiter pulls its FSM encoding and default sizes from here.
package segre_pkg;

  localparam int PHYS_ADDR_SIZE    = 32;
  localparam int LANE_BYTE_BITS    = 4;
  localparam int ICACHE_LANE_SIZE  = 128;
  localparam int ICACHE_INDEX_SIZE = 2;
  localparam int DCACHE_LANE_SIZE  = ICACHE_LANE_SIZE;
  localparam int DCACHE_INDEX_SIZE = ICACHE_INDEX_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } mem_arb_state_e;

  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } mem_arb_owner_e;

endpackage

// File: rtl/segre_mem_arbiter.sv
// Round-robin refill sequencer between icache, dcache and one memory port.
// Performs the dirty-victim write-back ahead of a dcache refill.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE     = PHYS_ADDR_SIZE,
  parameter int LANE_SIZE     = ICACHE_LANE_SIZE,
  parameter int BYTE_SIZE     = LANE_BYTE_BITS,
  parameter int IC_INDEX_SIZE = ICACHE_INDEX_SIZE,
  parameter int DC_INDEX_SIZE = DCACHE_INDEX_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     ic_miss_i,
  input  logic [ADDR_SIZE-1:0]     ic_addr_i,
  input  logic                     dc_miss_i,
  input  logic [ADDR_SIZE-1:0]     dc_addr_i,
  input  logic                     dc_wb_i,
  input  logic [ADDR_SIZE-1:0]     dc_wb_addr_i,
  input  logic [LANE_SIZE-1:0]     dc_wb_data_i,

  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_SIZE-1:0]     mem_addr_o,
  output logic [LANE_SIZE-1:0]     mem_wdata_o,
  input  logic                     mem_ready_i,
  input  logic [LANE_SIZE-1:0]     mem_rdata_i,

  output logic                     ic_fill_o,
  output logic [LANE_SIZE-1:0]     ic_fill_data_o,
  output logic [IC_INDEX_SIZE-1:0] ic_fill_index_o,
  output logic                     dc_fill_o,
  output logic [LANE_SIZE-1:0]     dc_fill_data_o,
  output logic [DC_INDEX_SIZE-1:0] dc_fill_index_o,

  output logic                     busy_o
);

  localparam logic [ADDR_SIZE-1:0] LANE_MASK =
    {{(ADDR_SIZE-BYTE_SIZE){1'b1}}, {BYTE_SIZE{1'b0}}};

  mem_arb_state_e            state;
  mem_arb_owner_e            owner;
  mem_arb_owner_e            last_grant;
  logic [1:0]                mask;
  logic [ADDR_SIZE-1:0]      fetch_addr;
  logic [ADDR_SIZE-1:0]      wb_addr;
  logic [LANE_SIZE-1:0]      wb_data;
  logic [IC_INDEX_SIZE-1:0]  ic_cnt;
  logic [DC_INDEX_SIZE-1:0]  dc_cnt;
  logic [LANE_SIZE-1:0]      ic_fill_data_q;
  logic [LANE_SIZE-1:0]      dc_fill_data_q;
  logic [IC_INDEX_SIZE-1:0]  ic_fill_index_q;
  logic [DC_INDEX_SIZE-1:0]  dc_fill_index_q;

  logic ic_elig;
  logic dc_elig;
  logic grant_any;
  logic grant_dc;

  // A requester just serviced sits out one IDLE cycle so its still-held
  // miss level cannot be granted twice.
  always_comb begin
    ic_elig   = ic_miss_i & ~mask[ARB_IC];
    dc_elig   = dc_miss_i & ~mask[ARB_DC];
    grant_any = ic_elig | dc_elig;
    grant_dc  = dc_elig & (~ic_elig | (last_grant == ARB_IC));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      owner           <= ARB_IC;
      last_grant      <= ARB_IC;
      mask            <= '0;
      fetch_addr      <= '0;
      wb_addr         <= '0;
      wb_data         <= '0;
      ic_cnt          <= '0;
      dc_cnt          <= '0;
      ic_fill_data_q  <= '0;
      dc_fill_data_q  <= '0;
      ic_fill_index_q <= '0;
      dc_fill_index_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          mask <= '0;
          if (grant_any) begin
            owner      <= grant_dc ? ARB_DC : ARB_IC;
            fetch_addr <= grant_dc ? dc_addr_i : ic_addr_i;
            wb_addr    <= dc_wb_addr_i;
            wb_data    <= dc_wb_data_i;
            state      <= (grant_dc && dc_wb_i) ? WB : FETCH;
          end
        end
        WB: begin
          if (mem_ready_i) state <= FETCH;
        end
        FETCH: begin
          if (mem_ready_i) begin
            // Index is captured here so the fill presents the pre-increment value.
            if (owner == ARB_DC) begin
              dc_fill_data_q  <= mem_rdata_i;
              dc_fill_index_q <= dc_cnt;
            end else begin
              ic_fill_data_q  <= mem_rdata_i;
              ic_fill_index_q <= ic_cnt;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (owner == ARB_DC) dc_cnt <= dc_cnt + 1'b1;
          else                 ic_cnt <= ic_cnt + 1'b1;
          last_grant <= owner;
          mask       <= (owner == ARB_DC) ? 2'b10 : 2'b01;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from state so the request drops
  // the moment reset forces state back to IDLE.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wb_addr & LANE_MASK;
        mem_wdata_o = wb_data;
      end
      FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fetch_addr & LANE_MASK;
      end
      default: ;
    endcase
  end

  assign ic_fill_o       = (state == RESP) && (owner == ARB_IC);
  assign dc_fill_o       = (state == RESP) && (owner == ARB_DC);
  assign ic_fill_data_o  = ic_fill_data_q;
  assign ic_fill_index_o = ic_fill_index_q;
  assign dc_fill_data_o  = dc_fill_data_q;
  assign dc_fill_index_o = dc_fill_index_q;
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Scoreboard bench for segre_mem_arbiter: expected memory requests and fills
// are queued at stimulus time; a memory model and a fill monitor check them.
module tb_segre_mem_arbiter;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ic_miss_i, dc_miss_i, dc_wb_i;
  logic [31:0]   ic_addr_i, dc_addr_i, dc_wb_addr_i;
  logic [127:0]  dc_wb_data_i;
  logic          mem_req_o, mem_we_o, mem_ready_i;
  logic [31:0]   mem_addr_o;
  logic [127:0]  mem_wdata_o, mem_rdata_i;
  logic          ic_fill_o, dc_fill_o, busy_o;
  logic [127:0]  ic_fill_data_o, dc_fill_data_o;
  logic [1:0]    ic_fill_index_o, dc_fill_index_o;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } req_t;

  typedef struct {
    logic         dc;
    logic [127:0] data;
    logic [1:0]   idx;
  } fill_t;

  req_t  exp_req[$];
  fill_t exp_fill[$];
  int    total = 0;
  int    bad = 0;
  int    mem_waits = 0;
  int    fills_seen = 0;
  logic [1:0] ic_idx_m = 2'd0;
  logic [1:0] dc_idx_m = 2'd0;

  segre_mem_arbiter dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ic_miss_i       (ic_miss_i),
    .ic_addr_i       (ic_addr_i),
    .dc_miss_i       (dc_miss_i),
    .dc_addr_i       (dc_addr_i),
    .dc_wb_i         (dc_wb_i),
    .dc_wb_addr_i    (dc_wb_addr_i),
    .dc_wb_data_i    (dc_wb_data_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_ready_i     (mem_ready_i),
    .mem_rdata_i     (mem_rdata_i),
    .ic_fill_o       (ic_fill_o),
    .ic_fill_data_o  (ic_fill_data_o),
    .ic_fill_index_o (ic_fill_index_o),
    .dc_fill_o       (dc_fill_o),
    .dc_fill_data_o  (dc_fill_data_o),
    .dc_fill_index_o (dc_fill_index_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] lane_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a, a + 32'h1234_5678};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // aligned_addr is the hand-computed lane-aligned address the DUT must emit.
  task automatic expect_read(input logic dc, input logic [31:0] aligned_addr);
    req_t  r;
    fill_t f;
    r.we    = 1'b0;
    r.addr  = aligned_addr;
    r.wdata = '0;
    exp_req.push_back(r);
    f.dc   = dc;
    f.data = lane_of(aligned_addr);
    f.idx  = dc ? dc_idx_m : ic_idx_m;
    if (dc) dc_idx_m = dc_idx_m + 2'd1;
    else    ic_idx_m = ic_idx_m + 2'd1;
    exp_fill.push_back(f);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [127:0] data);
    req_t r;
    r.we    = 1'b1;
    r.addr  = addr;
    r.wdata = data;
    exp_req.push_back(r);
  endtask

  // Runs until both misses are released and the arbiter is idle. Each miss is
  // held through the IDLE cycle after its fill, then dropped. lat = edges from
  // stimulus to the first fill strobe.
  task automatic serve(input int budget, output int lat);
    int ic_hold;
    int dc_hold;
    lat = -1;
    ic_hold = 0;
    dc_hold = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk_i); #1;
      if (ic_hold > 0) begin ic_hold--; if (ic_hold == 0) ic_miss_i = 1'b0; end
      if (dc_hold > 0) begin dc_hold--; if (dc_hold == 0) dc_miss_i = 1'b0; end
      if (ic_fill_o) begin ic_hold = 2; if (lat < 0) lat = n; end
      if (dc_fill_o) begin dc_hold = 2; if (lat < 0) lat = n; end
      if (!ic_miss_i && !dc_miss_i && !busy_o) return;
    end
    total++;
    bad++;
    $display("FAIL serve_timeout: got busy=%0b expected idle within %0d cycles", busy_o, budget);
  endtask

  // Memory model: answers after mem_waits stall cycles, checks each request.
  initial begin : mem_model
    int   wait_cnt;
    req_t r;
    wait_cnt    = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;
      if (rst_i || !mem_req_o) begin
        wait_cnt = 0;
      end else if (exp_req.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got we=%0b addr=%0h expected no request", mem_we_o, mem_addr_o);
        mem_ready_i = 1'b1;
      end else begin
        r = exp_req[0];
        check("req_we", mem_we_o, r.we);
        check("req_addr", mem_addr_o, r.addr);
        check("req_wdata", mem_wdata_o, r.wdata);
        if (wait_cnt >= mem_waits) begin
          mem_ready_i = 1'b1;
          if (!mem_we_o) mem_rdata_i = lane_of(mem_addr_o);
          void'(exp_req.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  fill_t mon_f;
  always @(negedge clk_i) begin
    if (!rst_i && (ic_fill_o || dc_fill_o)) begin
      fills_seen++;
      if (exp_fill.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fill: got ic=%0b dc=%0b expected none", ic_fill_o, dc_fill_o);
      end else begin
        mon_f = exp_fill.pop_front();
        check("fill_owner_dc", dc_fill_o, mon_f.dc);
        check("fill_owner_ic", ic_fill_o, !mon_f.dc);
        check("fill_data", mon_f.dc ? dc_fill_data_o : ic_fill_data_o, mon_f.data);
        check("fill_index", mon_f.dc ? dc_fill_index_o : ic_fill_index_o, mon_f.idx);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  lat;
    bit  found;
    rst_i        = 1'b1;
    ic_miss_i    = 1'b0;
    dc_miss_i    = 1'b0;
    dc_wb_i      = 1'b0;
    ic_addr_i    = '0;
    dc_addr_i    = '0;
    dc_wb_addr_i = '0;
    dc_wb_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req", mem_req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_fill", {ic_fill_o, dc_fill_o}, 2'b00);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_fill_data", {ic_fill_data_o, dc_fill_data_o}, 256'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // IC miss, two memory wait cycles: fill 4 cycles after the miss.
    mem_waits = 2;
    ic_addr_i = 32'h0000_1234;
    ic_miss_i = 1'b1;
    expect_read(1'b0, 32'h0000_1230);
    serve(50, lat);
    check("ic_wait2_latency", lat, 4);
    check("idle_addr", mem_addr_o, 32'h0);
    check("idle_we_wdata", {mem_we_o, mem_wdata_o}, 129'h0);

    // Zero-wait IC read, next index 1.
    mem_waits = 0;
    ic_addr_i = 32'h0000_200F;
    ic_miss_i = 1'b1;
    expect_read(1'b0, 32'h0000_2000);
    serve(50, lat);
    check("ic_wait0_latency", lat, 2);

    // Simultaneous misses: DC wins the first tie, IC follows.
    ic_addr_i = 32'h0000_5004;
    dc_addr_i = 32'h0000_6008;
    ic_miss_i = 1'b1;
    dc_miss_i = 1'b1;
    expect_read(1'b1, 32'h0000_6000);
    expect_read(1'b0, 32'h0000_5000);
    serve(60, lat);
    check("tie_first_latency", lat, 2);

    // Dirty victim: write-back of 0x80 then the refill read.
    dc_addr_i    = 32'h0000_4568;
    dc_wb_addr_i = 32'h0000_0080;
    dc_wb_data_i = {16{8'hA5}};
    dc_wb_i      = 1'b1;
    dc_miss_i    = 1'b1;
    expect_write(32'h0000_0080, {16{8'hA5}});
    expect_read(1'b1, 32'h0000_4560);
    serve(50, lat);
    check("wb_latency", lat, 3);
    dc_wb_i = 1'b0;

    // Reset during FETCH aborts the request and clears counters/outputs.
    mem_waits = 5;
    ic_addr_i = 32'h0000_3000;
    ic_miss_i = 1'b1;
    expect_read(1'b0, 32'h0000_3000);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge clk_i); #1;
      if (mem_req_o && !mem_we_o) found = 1'b1;
    end
    check("rst_fetch_reached", found, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async_req", mem_req_o, 1'b0);
    check("rst_async_busy", busy_o, 1'b0);
    ic_miss_i = 1'b0;
    exp_req.delete();
    exp_fill.delete();
    ic_idx_m = 2'd0;
    dc_idx_m = 2'd0;
    @(posedge clk_i); #1;
    check("rst_mid_ic_data", ic_fill_data_o, 128'h0);
    check("rst_mid_dc_index", dc_fill_index_o, 2'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Five IC fills after reset: indices 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      mem_waits = i % 2;
      ic_addr_i = 32'h0000_7000 + 32'(i) * 32'h100 + 32'h7;
      ic_miss_i = 1'b1;
      expect_read(1'b0, 32'h0000_7000 + 32'(i) * 32'h100);
      serve(50, lat);
    end

    // Miss dropped during FETCH: fill still happens once.
    mem_waits = 3;
    ic_addr_i = 32'h0000_9ABC;
    ic_miss_i = 1'b1;
    expect_read(1'b0, 32'h0000_9AB0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge clk_i); #1;
      if (mem_req_o) found = 1'b1;
    end
    check("drop_req_seen", found, 1'b1);
    ic_miss_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge clk_i); #1;
      if (ic_fill_o) found = 1'b1;
    end
    check("drop_fill_seen", found, 1'b1);
    repeat (4) @(posedge clk_i);
    #1;
    check("drop_idle_busy", busy_o, 1'b0);

    check("fills_total", fills_seen, 11);
    check("exp_fill_drained", exp_fill.size(), 0);
    check("exp_req_drained", exp_req.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
